// File: rtl/message_comm_rx.sv
// Receive side of the MSG serial link: oversamples the link, deserialises and buffers a frame,
// verifies its trailing CRC8 and streams the data bytes out through a valid/ready stage.
module message_comm_rx #(
    parameter int unsigned BUF_AW      = 11,
    parameter int unsigned CLK_TIMEOUT = 1024
) (
    input  logic        phy_rx_clk,
    input  logic        rst_n,
    input  logic        msg_clk_i,
    input  logic        msg_rx_fsx_i,
    input  logic        msg_rx_i,
    output logic        rx_byte_vld_o,
    output logic [7:0]  rx_byte_o,
    output logic        rx_byte_last_o,
    input  logic        rx_byte_rdy_i,
    output logic        rx_frame_ok_o,
    output logic [15:0] rx_frame_len_o,
    output logic        rx_crc_err_o,
    output logic        rx_len_err_o,
    output logic        rx_drop_o
);

    localparam int unsigned Depth = 2 ** BUF_AW;
    localparam int unsigned CntW  = BUF_AW + 1;
    localparam int unsigned TmoW  = $clog2(CLK_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StRecv, StDrop, StCheck, StDrain} state_e;

    state_e            state_q, state_d;
    logic [2:0]        clk_sync_q, fsx_sync_q, dat_sync_q;
    logic              fsx_prev_q, fsx_prev_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]        crc_q, crc_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [15:0]       len_q, len_d;
    logic              ok_q, ok_d, crc_err_q, crc_err_d, len_err_q, len_err_d, drop_q, drop_d;
    logic [CntW-1:0]   rd_ptr_q, rd_ptr_d;
    logic              rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
    logic [7:0]        rd_data_q;
    logic              vld_q, vld_d, last_q, last_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        mem [Depth];

    logic              msg_edge, fsx_smp, dat_smp, frame_start;
    logic              wr_en, check_pass, rd_load, rd_to_out;
    logic [7:0]        wr_byte;

    // No reset on the synchronisers so they track the link straight through a reset
    always_ff @(posedge phy_rx_clk) begin
        clk_sync_q <= {clk_sync_q[1:0], msg_clk_i};
        fsx_sync_q <= {fsx_sync_q[1:0], msg_rx_fsx_i};
        dat_sync_q <= {dat_sync_q[1:0], msg_rx_i};
    end

    assign msg_edge    = clk_sync_q[1] & ~clk_sync_q[2];
    assign fsx_smp     = fsx_sync_q[2];
    assign dat_smp     = dat_sync_q[2];
    assign frame_start = msg_edge & fsx_smp & ~fsx_prev_q;
    assign wr_byte     = {shift_q, dat_smp};

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        fsx_prev_d = msg_edge ? fsx_smp : fsx_prev_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        tmo_d      = '0;
        len_d      = len_q;
        ok_d       = 1'b0;
        crc_err_d  = 1'b0;
        len_err_d  = 1'b0;
        drop_d     = 1'b0;
        wr_en      = 1'b0;
        check_pass = 1'b0;

        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d    = StRecv;
                    bit_cnt_d  = 3'd6;
                    shift_d    = {6'd0, dat_smp};
                    byte_cnt_d = '0;
                    crc_d      = 8'hFF;
                end
            end
            StRecv: begin
                tmo_d = tmo_q + TmoW'(1);
                if (msg_edge) begin
                    tmo_d = '0;
                    if (!fsx_smp) begin
                        state_d = StCheck;
                    end else begin
                        shift_d   = {shift_q[5:0], dat_smp};
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            if (byte_cnt_q == CntW'(Depth)) begin
                                state_d   = StDrop;
                                len_err_d = 1'b1;
                            end else begin
                                wr_en      = 1'b1;
                                byte_cnt_d = byte_cnt_q + CntW'(1);
                                crc_d      = crc8_byte(crc_q, wr_byte);
                            end
                        end
                    end
                end else if (tmo_q == TmoW'(CLK_TIMEOUT - 1)) begin
                    state_d   = StIdle;
                    len_err_d = 1'b1;
                end
            end
            StDrop: begin
                if (msg_edge && !fsx_smp) state_d = StIdle;
            end
            StCheck: begin
                drop_d  = frame_start;
                state_d = StIdle;
                if (bit_cnt_q != 3'd7 || byte_cnt_q < CntW'(2)) begin
                    len_err_d = 1'b1;
                end else if (crc_q != 8'h00) begin
                    crc_err_d = 1'b1;
                end else begin
                    ok_d       = 1'b1;
                    len_d      = 16'(byte_cnt_q - CntW'(1));
                    state_d    = StDrain;
                    check_pass = 1'b1;
                end
            end
            StDrain: begin
                drop_d = frame_start;
                if (vld_q && rx_byte_rdy_i && last_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Two-deep drain pipe: buffer output register feeds the valid/ready output register
        rd_to_out = rd_vld_q & (~vld_q | rx_byte_rdy_i);
        rd_load   = check_pass |
                    ((state_q == StDrain) && (16'(rd_ptr_q) < len_q) && (!rd_vld_q || rd_to_out));
        rd_ptr_d  = '0;
        rd_vld_d  = 1'b0;
        rd_last_d = rd_last_q;
        vld_d     = 1'b0;
        byte_d    = byte_q;
        last_d    = last_q;
        if (state_q == StCheck || state_q == StDrain) begin
            rd_ptr_d = rd_ptr_q + CntW'(rd_load);
            rd_vld_d = rd_load | (rd_vld_q & ~rd_to_out);
            if (rd_load) rd_last_d = (16'(rd_ptr_q) + 16'd1 == len_d);
        end
        if (state_q == StDrain) begin
            vld_d = rd_to_out | (vld_q & ~rx_byte_rdy_i);
            if (rd_to_out) begin
                byte_d = rd_data_q;
                last_d = rd_last_q;
            end
        end
    end

    always_ff @(posedge phy_rx_clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fsx_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            crc_q      <= 8'hFF;
            tmo_q      <= '0;
            len_q      <= '0;
            ok_q       <= 1'b0;
            crc_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            drop_q     <= 1'b0;
            rd_ptr_q   <= '0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            vld_q      <= 1'b0;
            byte_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fsx_prev_q <= fsx_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            tmo_q      <= tmo_d;
            len_q      <= len_d;
            ok_q       <= ok_d;
            crc_err_q  <= crc_err_d;
            len_err_q  <= len_err_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_vld_q   <= rd_vld_d;
            rd_last_q  <= rd_last_d;
            vld_q      <= vld_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
        end
    end

    always_ff @(posedge phy_rx_clk) begin
        if (wr_en) mem[byte_cnt_q[BUF_AW-1:0]] <= wr_byte;
        if (rd_load) rd_data_q <= mem[rd_ptr_q[BUF_AW-1:0]];
    end

    assign rx_byte_vld_o  = vld_q;
    assign rx_byte_o      = byte_q;
    assign rx_byte_last_o = last_q;
    assign rx_frame_ok_o  = ok_q;
    assign rx_frame_len_o = len_q;
    assign rx_crc_err_o   = crc_err_q;
    assign rx_len_err_o   = len_err_q;
    assign rx_drop_o      = drop_q;

endmodule

// File: tb/tb_message_comm_rx.sv
// Bench for message_comm_rx: drives MSG frames bit by bit and compares outcome pulses and the
// drained byte stream with a frame-level model (CRC of data must equal the trailing byte).
module tb_message_comm_rx;

    localparam int unsigned BUF_AW      = 5;
    localparam int unsigned CLK_TIMEOUT = 64;
    localparam int          CAP         = 2 ** BUF_AW;

    typedef byte unsigned bq_t[$];

    logic        phy_rx_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        msg_clk_i = 1'b0;
    logic        msg_rx_fsx_i = 1'b0;
    logic        msg_rx_i = 1'b0;
    logic        rx_byte_rdy_i = 1'b1;
    logic        rx_byte_vld_o, rx_byte_last_o, rx_frame_ok_o, rx_crc_err_o, rx_len_err_o;
    logic        rx_drop_o;
    logic [7:0]  rx_byte_o;
    logic [15:0] rx_frame_len_o;

    message_comm_rx #(.BUF_AW(BUF_AW), .CLK_TIMEOUT(CLK_TIMEOUT)) dut (
        .phy_rx_clk    (phy_rx_clk),
        .rst_n         (rst_n),
        .msg_clk_i     (msg_clk_i),
        .msg_rx_fsx_i  (msg_rx_fsx_i),
        .msg_rx_i      (msg_rx_i),
        .rx_byte_vld_o (rx_byte_vld_o),
        .rx_byte_o     (rx_byte_o),
        .rx_byte_last_o(rx_byte_last_o),
        .rx_byte_rdy_i (rx_byte_rdy_i),
        .rx_frame_ok_o (rx_frame_ok_o),
        .rx_frame_len_o(rx_frame_len_o),
        .rx_crc_err_o  (rx_crc_err_o),
        .rx_len_err_o  (rx_len_err_o),
        .rx_drop_o     (rx_drop_o)
    );

    always #5 phy_rx_clk = ~phy_rx_clk;

    int errors = 0;
    int checks = 0;
    bit rand_rdy = 1'b0;
    bit rdy_hold = 1'b0;

    // Cumulative observations; the stimulus block works on deltas between snapshots
    int         ok_tot = 0, crc_tot = 0, len_tot = 0, drop_tot = 0, stall_viol = 0, excl_viol = 0;
    logic [15:0] last_len = '0;
    logic [8:0]  rx_q[$];
    bit          held_v = 1'b0;
    logic [7:0]  held_b;
    logic        held_l;

    always @(negedge phy_rx_clk) begin
        if (rx_frame_ok_o) begin
            ok_tot++;
            last_len = rx_frame_len_o;
        end
        if (rx_crc_err_o) crc_tot++;
        if (rx_len_err_o) len_tot++;
        if (rx_drop_o) drop_tot++;
        if (int'(rx_frame_ok_o) + int'(rx_crc_err_o) + int'(rx_len_err_o) > 1) excl_viol++;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v && !(rx_byte_vld_o && rx_byte_o == held_b && rx_byte_last_o == held_l))
                stall_viol++;
            held_v = rx_byte_vld_o & ~rx_byte_rdy_i;
            held_b = rx_byte_o;
            held_l = rx_byte_last_o;
            if (rx_byte_vld_o && rx_byte_rdy_i) rx_q.push_back({rx_byte_last_o, rx_byte_o});
        end
    end

    initial begin
        forever begin
            @(posedge phy_rx_clk);
            #1;
            rx_byte_rdy_i = rdy_hold ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input bq_t d);
        logic [7:0] c;
        c = 8'hFF;
        foreach (d[k]) begin
            c = c ^ d[k];
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    function automatic bq_t make_frame(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        q.push_back(crc8(q));
        return q;
    endfunction

    task automatic msg_bit(input logic f, input logic d);
        msg_rx_fsx_i = f;
        msg_rx_i     = d;
        #40 msg_clk_i = 1'b1;
        #40 msg_clk_i = 1'b0;
    endtask

    task automatic send(input bq_t b, input int extra);
        foreach (b[k]) for (int i = 7; i >= 0; i--) msg_bit(1'b1, b[k][i]);
        repeat (extra) msg_bit(1'b1, 1'b1);
        msg_bit(1'b0, 1'b0);
        msg_bit(1'b0, 1'b0);
    endtask

    int s_ok, s_crc, s_len, s_drop, s_rx, s_stall, s_excl;

    task automatic snap();
        s_ok = ok_tot; s_crc = crc_tot; s_len = len_tot; s_drop = drop_tot;
        s_rx = rx_q.size(); s_stall = stall_viol; s_excl = excl_viol;
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 3000; i++) begin
            if (rx_q.size() - s_rx >= n) break;
            @(negedge phy_rx_clk);
        end
        repeat (30) @(negedge phy_rx_clk);
    endtask

    task automatic expect_frame(input string tag, input int e_ok, input int e_crc, input int e_len,
                                input int e_drop, input bq_t data);
        check({tag, ".ok"}, ok_tot - s_ok, e_ok);
        check({tag, ".crc_err"}, crc_tot - s_crc, e_crc);
        check({tag, ".len_err"}, len_tot - s_len, e_len);
        check({tag, ".drop"}, drop_tot - s_drop, e_drop);
        check({tag, ".nbytes"}, rx_q.size() - s_rx, data.size());
        foreach (data[i]) begin
            if (s_rx + i < rx_q.size())
                check($sformatf("%s.byte%0d", tag, i), rx_q[s_rx + i],
                      {(i == data.size() - 1) ? 1'b1 : 1'b0, data[i]});
        end
        if (e_ok != 0 && data.size() > 0) check({tag, ".len"}, last_len, data.size());
        check({tag, ".stall_stable"}, stall_viol - s_stall, 0);
        check({tag, ".pulse_excl"}, excl_viol - s_excl, 0);
    endtask

    // Frame-level reference: classify by whole bytes, then CRC of data vs. trailing byte
    task automatic run(input string tag, input bq_t f, input int extra);
        bq_t data;
        int  nb, e_ok, e_crc, e_len;
        nb = (f.size() * 8 + extra) / 8;
        e_ok = 0; e_crc = 0; e_len = 0;
        if (nb > CAP) e_len = 1;
        else if (extra % 8 != 0 || nb < 2) e_len = 1;
        else if (f[f.size() - 1] == crc8(f[0:f.size() - 2])) begin
            e_ok = 1;
            data = f[0:f.size() - 2];
        end else e_crc = 1;
        snap();
        send(f, extra);
        wait_rx(data.size());
        expect_frame(tag, e_ok, e_crc, e_len, 0, data);
    endtask

    bq_t f, fa, fb, empty;

    initial begin
        repeat (4) @(posedge phy_rx_clk);
        @(negedge phy_rx_clk);
        check("rst.vld", rx_byte_vld_o, 0);
        check("rst.byte", rx_byte_o, 0);
        check("rst.last", rx_byte_last_o, 0);
        check("rst.ok", rx_frame_ok_o, 0);
        check("rst.len", rx_frame_len_o, 0);
        check("rst.crc_err", rx_crc_err_o, 0);
        check("rst.len_err", rx_len_err_o, 0);
        check("rst.drop", rx_drop_o, 0);
        @(posedge phy_rx_clk);
        #1 rst_n = 1'b1;
        msg_bit(1'b0, 1'b0);
        msg_bit(1'b0, 1'b0);

        f = '{8'h01, 8'hF4};
        run("t1_ok", f, 0);
        f = '{8'h01, 8'hF5};
        run("t2_crc", f, 0);
        f = '{8'hFF};
        run("t3_9bits", f, 1);
        run("t3_1byte", f, 0);
        run("t4_ovf", make_frame(CAP), 0);
        run("t4_next", make_frame(3), 0);

        rand_rdy = 1'b1;
        run("t5_16B", make_frame(16), 0);
        for (int k = 0; k < 6; k++) begin
            f = make_frame($urandom_range(1, 24));
            if ($urandom_range(0, 2) == 0) begin
                int idx;
                idx = $urandom_range(0, f.size() - 1);
                f[idx] = f[idx] ^ (8'h01 << $urandom_range(0, 7));
            end
            run($sformatf("rnd%0d", k), f, 0);
        end

        snap();
        repeat (5) msg_bit(1'b1, 1'b1);
        repeat (CLK_TIMEOUT + 20) @(posedge phy_rx_clk);
        msg_bit(1'b0, 1'b0);
        msg_bit(1'b0, 1'b0);
        wait_rx(0);
        expect_frame("timeout", 0, 0, 1, 0, empty);
        run("after_tmo", make_frame(4), 0);

        rand_rdy = 1'b0;
        rdy_hold = 1'b1;
        fa = make_frame(16);
        fb = make_frame(4);
        snap();
        send(fa, 0);
        send(fb, 0);
        rdy_hold = 1'b0;
        wait_rx(16);
        expect_frame("t6_drop", 1, 0, 0, 1, fa[0:15]);

        f = make_frame(10);
        snap();
        fork
            send(f, 0);
            begin
                #2000;
                @(posedge phy_rx_clk);
                #1 rst_n = 1'b0;
                repeat (3) @(posedge phy_rx_clk);
                #1 rst_n = 1'b1;
            end
        join
        wait_rx(0);
        expect_frame("t6_rst_frame", 0, 0, 0, 0, empty);
        run("after_rst", make_frame(5), 0);

        rdy_hold = 1'b1;
        snap();
        send(make_frame(6), 0);
        repeat (5) @(negedge phy_rx_clk);
        check("drain.vld_stalled", rx_byte_vld_o, 1);
        @(posedge phy_rx_clk);
        #1 rst_n = 1'b0;
        @(posedge phy_rx_clk);
        @(negedge phy_rx_clk);
        check("drain.vld_in_rst", rx_byte_vld_o, 0);
        check("drain.len_in_rst", rx_frame_len_o, 0);
        @(posedge phy_rx_clk);
        #1 rst_n = 1'b1;
        rdy_hold = 1'b0;
        wait_rx(0);
        expect_frame("t6_rst_drain", 1, 0, 0, 0, empty);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
